// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_ctrl_pkg
// Purpose  : Shared state encoding and default width for the bit-serial adder
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_ctrl_fa
// Purpose  : 1-bit full-adder cell used as the time-shared serial datapath
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial WIDTH-bit adder controller; one full-adder cell is
//            reused for WIDTH cycles, LSB first, with carry fed back.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   res_next;

  // Single shared full-adder cell working on the current LSBs
  serial_adder_ctrl_fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Result shift register value including this cycle's sum bit
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  // Controller FSM, operand/result shifters, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Operands are captured only here; later input changes are ignored
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          carry  <= fa_co;
          if (cnt == LAST_BIT) begin
            // sum/cout only change here, so they hold across a new operation
            cnt   <= '0;
            sum   <= res_next;
            cout  <= fa_co;
            state <= ST_DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_serial_adder_ctrl
// Purpose  : Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] sum4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done8_total = 0;
  int done4_total = 0;

  logic [8:0] exp8[$];
  logic [4:0] exp4[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done8) done8_total++;
    if (done4) done4_total++;
  end

  // Drive one operation on the 8-bit DUT; returns after the accepting edge
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    exp8.push_back({1'b0, av} + {1'b0, bv} + 9'(cv));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done on the 8-bit DUT, counting busy cycles seen
  task automatic wait_done8(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done8) got = 1'b1;
      else if (busy8) busy_cycles++;
    end
  endtask

  task automatic check_pop8(input string name);
    logic [8:0] e;
    total++;
    if (exp8.size() == 0) begin
      bad++;
      $display("FAIL %s: result {cout,sum}=%h but no expectation queued", name, {cout8, sum8});
    end else begin
      e = exp8.pop_front();
      if ({cout8, sum8} !== e) begin
        bad++;
        $display("FAIL %s: {cout,sum} got=%h expected=%h", name, {cout8, sum8}, e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({ready8, busy8, done8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset8: rdy/busy/done/cout/sum got=%b/%b/%b/%b/%h expected=1/0/0/0/00",
               ready8, busy8, done8, cout8, sum8);
    end
    total++;
    if ({ready4, busy4, done4, cout4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL reset4: rdy/busy/done/cout/sum got=%b/%b/%b/%b/%h expected=1/0/0/0/0",
               ready4, busy4, done4, cout4, sum4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bc; bit got;
    issue8(8'h5A, 8'h3C, 1'b0);
    wait_done8(bc, got);
    total++;
    if (!got || bc != 8) begin
      bad++;
      $display("FAIL basic_latency: done_seen=%0d busy_cycles=%0d expected done_seen=1 busy_cycles=8", got, bc);
    end
    if (got) check_pop8("basic_sum");
    @(negedge clk);
    total++;
    if ({done8, ready8, sum8} !== {1'b0, 1'b1, 8'h96}) begin
      bad++;
      $display("FAIL basic_hold: done/ready/sum got=%b/%b/%h expected=0/1/96", done8, ready8, sum8);
    end
  endtask

  task automatic test_wrap();
    int bc; bit got;
    issue8(8'hFF, 8'h01, 1'b0);
    wait_done8(bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL wrap1_timeout: done_seen=0 expected=1"); end
    else check_pop8("wrap_ff_01");
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8(bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL wrap2_timeout: done_seen=0 expected=1"); end
    else check_pop8("wrap_ff_ff_1");
  endtask

  task automatic test_back_to_back();
    int dcyc[2];
    int nd = 0;
    int viol = 0;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    exp8.push_back(9'h003);
    exp8.push_back(9'h030);
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20;
    for (int i = 0; i < 40 && nd < 2; i++) begin
      @(negedge clk);
      if (ready8 !== done8 || busy8 !== !ready8) viol++;
      if (done8) begin
        dcyc[nd] = cyc;
        check_pop8(nd == 0 ? "b2b_first" : "b2b_second");
        nd++;
        if (nd == 2) start8 = 1'b0;
      end
    end
    total++;
    if (nd != 2) begin
      bad++;
      $display("FAIL b2b_count: done pulses=%0d expected=2", nd);
    end else begin
      total++;
      if (dcyc[1] - dcyc[0] != 9) begin
        bad++;
        $display("FAIL b2b_spacing: got=%0d cycles expected=9", dcyc[1] - dcyc[0]);
      end
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL b2b_ready: ready/busy decode violations=%0d expected=0", viol);
    end
    @(negedge clk);
    total++;
    if ({ready8, busy8} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_idle: ready/busy got=%b/%b expected=1/0", ready8, busy8);
    end
  endtask

  task automatic test_ignore_start();
    int bc; bit got; int d0;
    d0 = done8_total;
    issue8(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL ignore_timeout: done_seen=0 expected=1"); end
    else check_pop8("ignore_sum");
    repeat (14) @(negedge clk);
    total++;
    if (done8_total - d0 != 1) begin
      bad++;
      $display("FAIL ignore_pulses: done pulses=%0d expected=1", done8_total - d0);
    end
  endtask

  task automatic test_reset_mid();
    int bc; bit got; int d0;
    d0 = done8_total;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready8, busy8, done8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL midreset: rdy/busy/done/cout/sum got=%b/%b/%b/%b/%h expected=1/0/0/0/00",
               ready8, busy8, done8, cout8, sum8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    total++;
    if (done8_total != d0) begin
      bad++;
      $display("FAIL midreset_pulse: done pulses=%0d expected=0", done8_total - d0);
    end
    issue8(8'h01, 8'h01, 1'b0);
    wait_done8(bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL midreset_after_timeout: done_seen=0 expected=1"); end
    else check_pop8("midreset_after");
  endtask

  task automatic test_sweep4();
    int d0;
    bit got;
    logic [4:0] e;
    d0 = done4_total;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(posedge clk); #1;
          start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
          exp4.push_back(5'(ai + bi + ci));
          @(posedge clk); #1;
          start4 = 1'b0;
          got = 1'b0;
          for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done4) got = 1'b1;
          end
          total++;
          if (!got) begin
            bad++;
            $display("FAIL sweep4_timeout: a=%h b=%h cin=%0d done_seen=0 expected=1", a4, b4, cin4);
            void'(exp4.pop_front());
          end else begin
            e = exp4.pop_front();
            if ({cout4, sum4} !== e) begin
              bad++;
              $display("FAIL sweep4: a=%h b=%h cin=%0d got=%h expected=%h", ai, bi, ci, {cout4, sum4}, e);
            end
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (done4_total - d0 != 512) begin
      bad++;
      $display("FAIL sweep4_pulses: done pulses=%0d expected=512", done4_total - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_sweep4();
    total++;
    if (exp8.size() != 0) begin
      bad++;
      $display("FAIL scoreboard8_leftover: entries=%0d expected=0", exp8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
